// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants, state encoding and elaboration helpers for the
// sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] ADJ_THRESH = 4'd5;
    localparam logic [BCD_W-1:0] ADJ_ADD    = 4'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic longint pow10(input int n);
        longint p;
        p = 64'sd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'sd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_adj_digit.sv
// Single-nibble double-dabble correction: values of 5 or more get +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_adj_digit
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] dout
);

    // Nibble adjust, wraps within 4 bits (cannot overflow for legal inputs 0..9)
    always_comb begin
        if (din >= ADJ_THRESH) begin
            dout = din + ADJ_ADD;
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per cycle,
// with a start/busy/done handshake and a leading-zero blanking mask.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 4
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin,
    output logic                      busy,
    output logic                      done,
    output logic [BCD_W*DIGITS-1:0]   BCD,
    output logic [DIGITS-1:0]         LZ
);

    localparam int CNT_W = clog2(BIN_W + 1);
    localparam int S_W   = BCD_W * DIGITS;
    localparam logic [DIGITS-1:0] LZ_RST = {{(DIGITS-1){1'b1}}, 1'b0};
    localparam longint MAX_BIN = (64'sd1 <<< BIN_W) - 64'sd1;

    if (MAX_BIN >= pow10(DIGITS)) begin : g_range_check
        $error("bin_to_bcd_seq: 2^BIN_W-1 does not fit in DIGITS decimal digits");
    end

    state_t             state_r, state_s;
    logic [BIN_W-1:0]   sr_r, sr_s;
    logic [S_W-1:0]     s_r, s_s, adj_s, s_shift_s;
    logic [S_W-1:0]     bcd_r, bcd_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [DIGITS-1:0]  lz_r, lz_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_adj_digit u_adj (
            .din  (s_r[g*BCD_W +: BCD_W]),
            .dout (adj_s[g*BCD_W +: BCD_W])
        );
    end

    // The top adjusted bit is dropped: it is always 0 once the range check holds
    assign s_shift_s = {adj_s[S_W-2:0], sr_r[BIN_W-1]};

    function automatic logic [DIGITS-1:0] lz_calc(input logic [S_W-1:0] v);
        logic [DIGITS-1:0] r;
        logic              zero;
        r    = {DIGITS{1'b0}};
        zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero = zero & (v[i*BCD_W +: BCD_W] == {BCD_W{1'b0}});
            r[i] = zero;
        end
        r[0] = 1'b0;
        return r;
    endfunction

    // Next-state and datapath update for the IDLE/SHIFT controller
    always_comb begin
        state_s = state_r;
        sr_s    = sr_r;
        s_s     = s_r;
        cnt_s   = cnt_r;
        bcd_s   = bcd_r;
        lz_s    = lz_r;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_SHIFT;
                    sr_s    = bin;
                    s_s     = {S_W{1'b0}};
                    cnt_s   = CNT_W'(BIN_W);
                    busy_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                s_s   = s_shift_s;
                sr_s  = {sr_r[BIN_W-2:0], 1'b0};
                cnt_s = cnt_r - CNT_W'(1);
                if (cnt_r == CNT_W'(1)) begin
                    state_s = ST_IDLE;
                    bcd_s   = s_shift_s;
                    lz_s    = lz_calc(s_shift_s);
                    done_s  = 1'b1;
                end else begin
                    busy_s  = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any conversion in flight
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            sr_r    <= {BIN_W{1'b0}};
            s_r     <= {S_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            bcd_r   <= {S_W{1'b0}};
            lz_r    <= LZ_RST;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            sr_r    <= sr_s;
            s_r     <= s_s;
            cnt_r   <= cnt_s;
            bcd_r   <= bcd_s;
            lz_r    <= lz_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign BCD  = bcd_r;
    assign LZ   = lz_r;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed vector table, full-range
// sweep against a decimal reference, and handshake/reset corner sequences.
module tb_bin_to_bcd_seq;

    logic        clock;
    logic        resetn;
    logic        start;
    logic [9:0]  bin;
    logic        busy;
    logic        done;
    logic [15:0] BCD;
    logic [3:0]  LZ;

    int tests;
    int fails;

    typedef struct {
        logic [9:0]  bin;
        logic [15:0] bcd;
        logic [3:0]  lz;
    } vec_t;

    vec_t vecs[11];

    bin_to_bcd_seq #(.BIN_W(10), .DIGITS(4)) dut (
        .clock  (clock),
        .resetn (resetn),
        .start  (start),
        .bin    (bin),
        .busy   (busy),
        .done   (done),
        .BCD    (BCD),
        .LZ     (LZ)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int d;
        d = v;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(d % 10);
            d = d / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] ref_lz(input int v);
        logic [3:0] r;
        int p;
        r = 4'b0000;
        p = 1;
        for (int i = 1; i < 4; i++) begin
            p = p * 10;
            r[i] = (v < p);
        end
        return r;
    endfunction

    // Start a conversion and wait (bounded) for done; bin is scrambled after acceptance
    task automatic convert(input logic [9:0] v, output int lat, output int busy_n);
        bin   = v;
        start = 1'b1;
        tick();
        start  = 1'b0;
        bin    = ~v;
        lat    = 0;
        busy_n = busy ? 1 : 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (done) begin
                lat = n;
                break;
            end
            if (busy) busy_n++;
        end
    endtask

    task automatic pulse_checks();
        check("busy_done_excl", {31'd0, busy & done}, 32'd0);
        tick();
        check("done_width", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int lat;
        int bn;
        int dones;
        logic nib_ok;
        logic held_ok;

        tests = 0;
        fails = 0;
        vecs[0]  = '{10'd0,    16'h0000, 4'b1110};
        vecs[1]  = '{10'd1023, 16'h1023, 4'b0000};
        vecs[2]  = '{10'd255,  16'h0255, 4'b1000};
        vecs[3]  = '{10'd7,    16'h0007, 4'b1110};
        vecs[4]  = '{10'd9,    16'h0009, 4'b1110};
        vecs[5]  = '{10'd10,   16'h0010, 4'b1100};
        vecs[6]  = '{10'd99,   16'h0099, 4'b1100};
        vecs[7]  = '{10'd100,  16'h0100, 4'b1000};
        vecs[8]  = '{10'd999,  16'h0999, 4'b1000};
        vecs[9]  = '{10'd1000, 16'h1000, 4'b0000};
        vecs[10] = '{10'd500,  16'h0500, 4'b1000};

        resetn = 1'b0;
        start  = 1'b0;
        bin    = 10'd0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_bcd",  {16'd0, BCD}, 32'h0000);
        check("rst_lz",   {28'd0, LZ},  32'hE);
        resetn = 1'b1;
        tick();

        // First conversion of zero: exact latency and busy window
        convert(10'd0, lat, bn);
        check("zero_latency", lat, 32'd10);
        check("zero_busy_cycles", bn, 32'd10);
        check("zero_bcd", {16'd0, BCD}, 32'h0000);
        check("zero_lz", {28'd0, LZ}, 32'hE);
        pulse_checks();

        for (int i = 0; i < 11; i++) begin
            convert(vecs[i].bin, lat, bn);
            check("vec_latency", lat, 32'd10);
            check("vec_bcd", {16'd0, BCD}, {16'd0, vecs[i].bcd});
            check("vec_lz", {28'd0, LZ}, {28'd0, vecs[i].lz});
            pulse_checks();
        end

        for (int v = 0; v < 1024; v++) begin
            convert(10'(v), lat, bn);
            nib_ok = 1'b1;
            for (int d = 0; d < 4; d++) begin
                if (BCD[d*4 +: 4] > 4'd9) nib_ok = 1'b0;
            end
            check("sweep_latency", lat, 32'd10);
            check("sweep_bcd", {16'd0, BCD}, {16'd0, ref_bcd(v)});
            check("sweep_lz", {28'd0, LZ}, {28'd0, ref_lz(v)});
            check("sweep_nibble_le9", {31'd0, nib_ok}, 32'd1);
            pulse_checks();
        end

        // Start requests during SHIFT are ignored, then a start on the done cycle is taken
        bin   = 10'd500;
        start = 1'b1;
        tick();
        dones = 0;
        lat   = 0;
        for (int n = 1; n <= 10; n++) begin
            if (n == 3 || n == 6) begin
                start = 1'b1;
                bin   = 10'd999;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) begin
                dones++;
                lat = n;
            end
        end
        check("ignore_done_count", dones, 32'd1);
        check("ignore_latency", lat, 32'd10);
        check("ignore_bcd", {16'd0, BCD}, 32'h0500);
        bin   = 10'd42;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_accepted_busy", {31'd0, busy}, 32'd1);
        check("b2b_bcd_held", {16'd0, BCD}, 32'h0500);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (done) begin
                lat = n;
                break;
            end
        end
        check("b2b_latency", lat, 32'd10);
        check("b2b_bcd", {16'd0, BCD}, 32'h0042);
        check("b2b_lz", {28'd0, LZ}, 32'hC);
        tick();

        // Asynchronous reset in the middle of a conversion
        bin   = 10'd777;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("midrst_pre_busy", {31'd0, busy}, 32'd1);
        resetn = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_bcd", {16'd0, BCD}, 32'h0000);
        check("midrst_lz", {28'd0, LZ}, 32'hE);
        tick();
        resetn = 1'b1;
        dones = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (done || busy) dones++;
        end
        check("midrst_no_done", dones, 32'd0);

        // Old result is held until the new done edge
        convert(10'd123, lat, bn);
        check("hold_first_bcd", {16'd0, BCD}, 32'h0123);
        tick();
        bin   = 10'd9;
        start = 1'b1;
        tick();
        start   = 1'b0;
        held_ok = 1'b1;
        lat     = 0;
        for (int n = 1; n <= 20; n++) begin
            if (BCD !== 16'h0123) held_ok = 1'b0;
            tick();
            if (done) begin
                lat = n;
                break;
            end
        end
        check("hold_old_value", {31'd0, held_ok}, 32'd1);
        check("hold_latency", lat, 32'd10);
        check("hold_new_bcd", {16'd0, BCD}, 32'h0009);
        check("hold_new_lz", {28'd0, LZ}, 32'hE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
